// File: rtl/bcd_run_ctrl.sv
// bcd_run_ctrl: debounced run/pause/clear sequencer for a 2-digit BCD counter.
// Optional `define ONESHOT_EN adds a DONE state that stops at terminal count.
module bcd_run_ctrl_deb #(
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic ev
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CLAST = CW'(DEBOUNCE_CYC - 1);

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_d;
  logic          lvl_p_q;
  logic          ev_q, ev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CLAST) lvl_d = s2_q;
      else cnt_d = cnt_q + 1'b1;
    end
    ev_d = lvl_q & ~lvl_p_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      lvl_q   <= 1'b0;
      lvl_p_q <= 1'b0;
      cnt_q   <= '0;
      ev_q    <= 1'b0;
    end else begin
      s1_q    <= btn;
      s2_q    <= s1_q;
      lvl_q   <= lvl_d;
      lvl_p_q <= lvl_q;
      cnt_q   <= cnt_d;
      ev_q    <= ev_d;
    end
  end

  assign ev = ev_q;
endmodule

module bcd_run_ctrl #(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned TICK_HZ      = 1,
  parameter int unsigned DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_ss,
  input  logic btn_clr,
  input  logic up_dn,
  input  logic cnt_tc,
  output logic cnt_en,
  output logic cnt_clr,
  output logic cnt_up,
  output logic running,
  output logic done
);
  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);
  localparam logic [PW-1:0] PLAST = PW'(DIV - 1);

`ifdef ONESHOT_EN
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
`endif

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          en_q, en_d;
  logic          clr_q, clr_d;
  logic          up_q, up_d;
  logic          run_q, run_d;
  logic          ev_ss, ev_clr;
  logic          wrap;

  bcd_run_ctrl_deb #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_ss (
    .clk(clk), .rst(rst), .btn(btn_ss), .ev(ev_ss)
  );

  bcd_run_ctrl_deb #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_clr (
    .clk(clk), .rst(rst), .btn(btn_clr), .ev(ev_clr)
  );

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    up_d    = up_q;
    en_d    = 1'b0;
    clr_d   = 1'b0;
    wrap    = (state_q == RUN) && (pre_q == PLAST);
    if (state_q == RUN) pre_d = wrap ? '0 : pre_q + 1'b1;
    // clear outranks start/stop and suppresses any tick on the same edge
    if (ev_clr) begin
      state_d = IDLE;
      pre_d   = '0;
      clr_d   = 1'b1;
    end else begin
      en_d = wrap;
      unique case (state_q)
        IDLE: begin
          if (ev_ss) begin
            state_d = RUN;
            up_d    = up_dn;
          end
        end
        RUN: begin
`ifdef ONESHOT_EN
          if (en_q && cnt_tc) state_d = DONE;
          else if (ev_ss) state_d = PAUSE;
`else
          if (ev_ss) state_d = PAUSE;
`endif
        end
        PAUSE: begin
          if (ev_ss) state_d = RUN;
        end
`ifdef ONESHOT_EN
        DONE: begin
          if (ev_ss) begin
            state_d = RUN;
            clr_d   = 1'b1;
            up_d    = up_dn;
            pre_d   = '0;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
    run_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      up_q    <= 1'b1;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      up_q    <= up_d;
      run_q   <= run_d;
    end
  end

`ifdef ONESHOT_EN
  logic done_q, done_d;

  assign done_d = (state_d == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_q <= 1'b0;
    else done_q <= done_d;
  end

  assign done = done_q;
`else
  logic unused_tc;

  assign unused_tc = cnt_tc;
  assign done      = 1'b0;
`endif

  assign cnt_en  = en_q;
  assign cnt_clr = clr_q;
  assign cnt_up  = up_q;
  assign running = run_q;
endmodule

// File: tb/tb_bcd_run_ctrl.sv
// tb_bcd_run_ctrl: scenario tasks plus randomized traffic against a
// behavioural model of button acceptance, run/pause/clear and tick timing.
module tb_bcd_run_ctrl;
  localparam int D   = 4;
  localparam int DIV = 10;

  logic clk, rst;
  logic btn_ss, btn_clr, up_dn, cnt_tc;
  logic cnt_en, cnt_clr, cnt_up, running, done;
  logic [4:0] outs;

  int checks;
  int failures;

  // model: accepted level, run length of differing samples, event delay line
  bit       acc[2];
  int       run_len[2];
  bit [3:0] dly[2];
  bit       m_run, m_pause, m_done, m_en, m_clr, m_up;
  int       rcnt;

  bcd_run_ctrl #(
    .CLK_HZ(10), .TICK_HZ(1), .DEBOUNCE_CYC(D)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_ss(btn_ss), .btn_clr(btn_clr),
    .up_dn(up_dn), .cnt_tc(cnt_tc),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .cnt_up(cnt_up), .running(running),
    .done(done)
  );

  assign outs = {cnt_en, cnt_clr, cnt_up, running, done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] expv();
    return {m_en, m_clr, m_up, m_run, m_done};
  endfunction

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) begin
      acc[b] = 0;
      run_len[b] = 0;
      dly[b] = '0;
    end
    m_run = 0; m_pause = 0; m_done = 0;
    m_en = 0; m_clr = 0; m_up = 1;
    rcnt = 0;
  endfunction

  function automatic void model_step();
    bit raw[2];
    bit ev[2];
    bit nw, tick;
`ifdef ONESHOT_EN
    bit pen;
    pen = m_en;
`endif
    raw[0] = btn_ss;
    raw[1] = btn_clr;
    for (int b = 0; b < 2; b++) begin
      nw = 0;
      ev[b] = dly[b][3];
      if (raw[b] != acc[b]) begin
        run_len[b]++;
        if (run_len[b] == D) begin
          acc[b] = raw[b];
          run_len[b] = 0;
          nw = raw[b];
        end
      end else begin
        run_len[b] = 0;
      end
      dly[b] = {dly[b][2:0], nw};
    end
    tick = 0;
    if (m_run) begin
      rcnt++;
      tick = (rcnt % DIV == 0);
    end
    m_en = 0;
    m_clr = 0;
    if (ev[1]) begin
      m_run = 0; m_pause = 0; m_done = 0;
      m_clr = 1;
      rcnt = 0;
    end else begin
      m_en = tick;
      if (m_run) begin
`ifdef ONESHOT_EN
        if (pen && cnt_tc) begin
          m_run = 0; m_done = 1;
        end else
`endif
        if (ev[0]) begin
          m_run = 0; m_pause = 1;
        end
      end else if (m_pause) begin
        if (ev[0]) begin
          m_pause = 0; m_run = 1;
        end
      end else if (m_done) begin
        if (ev[0]) begin
          m_done = 0; m_run = 1; m_clr = 1;
          m_up = up_dn; rcnt = 0;
        end
      end else if (ev[0]) begin
        m_run = 1;
        m_up = up_dn;
      end
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    btn_ss = 0; btn_clr = 0; up_dn = 1; cnt_tc = 0;
    rst = 1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    btn_ss = 0; btn_clr = 0; up_dn = 1; cnt_tc = 0;
    rst = 1;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== 5'b00100) begin
      failures++;
      $display("FAIL reset_vals dut=%b exp=%b", outs, 5'b00100);
    end
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (outs !== expv()) begin
        failures++;
        $display("FAIL reset_idle i=%0d dut=%b exp=%b", i, outs, expv());
      end
    end
  endtask

  task automatic test_glitch();
    int act;
    do_reset();
    act = 0;
    for (int i = 0; i < 25; i++) begin
      btn_ss = (i < 3);
      cyc();
      checks++;
      if (outs !== expv()) begin
        failures++;
        $display("FAIL glitch i=%0d dut=%b exp=%b", i, outs, expv());
      end
      if (running || cnt_en) act++;
    end
    checks++;
    if (act !== 0) begin
      failures++;
      $display("FAIL glitch_act dut=%0d exp=0", act);
    end
  endtask

  task automatic test_start();
    int rise, first_en, last_en, n_en;
    bit gap_ok;
    do_reset();
    rise = -1; first_en = -1; last_en = -1;
    n_en = 0; gap_ok = 1;
    for (int i = 0; i < 48; i++) begin
      btn_ss = (i < 8);
      cyc();
      checks++;
      if (outs !== expv()) begin
        failures++;
        $display("FAIL start i=%0d dut=%b exp=%b", i, outs, expv());
      end
      if (running && rise < 0) rise = i;
      if (cnt_en) begin
        if (first_en < 0) first_en = i;
        else if (i - last_en != DIV) gap_ok = 0;
        last_en = i;
        n_en++;
      end
    end
    checks++;
    if (rise !== 7) begin
      failures++;
      $display("FAIL start_rise dut=%0d exp=7", rise);
    end
    checks++;
    if (first_en - rise !== DIV) begin
      failures++;
      $display("FAIL start_first_en dut=%0d exp=%0d", first_en - rise, DIV);
    end
    checks++;
    if (!gap_ok || n_en !== 4) begin
      failures++;
      $display("FAIL start_period n=%0d ok=%0d exp n=4 ok=1", n_en, gap_ok);
    end
  endtask

  task automatic test_pause();
    int fall, rise2, en_after, en_pause;
    bit seen_fall;
    do_reset();
    fall = -1; rise2 = -1; en_after = -1;
    en_pause = 0; seen_fall = 0;
    for (int i = 0; i < 110; i++) begin
      btn_ss = (i < 8) || (i >= 34 && i < 40) || (i >= 84 && i < 90);
      cyc();
      checks++;
      if (outs !== expv()) begin
        failures++;
        $display("FAIL pause i=%0d dut=%b exp=%b", i, outs, expv());
      end
      if (i > 7 && !running && fall < 0) fall = i;
      if (fall >= 0 && rise2 < 0 && running) rise2 = i;
      if (fall >= 0 && rise2 < 0 && cnt_en) en_pause++;
      if (rise2 >= 0 && en_after < 0 && cnt_en) en_after = i;
    end
    checks++;
    if (fall !== 41 || rise2 !== 91) begin
      failures++;
      $display("FAIL pause_edges fall=%0d rise=%0d exp 41 91", fall, rise2);
    end
    checks++;
    if (en_pause !== 0) begin
      failures++;
      $display("FAIL pause_no_en dut=%0d exp=0", en_pause);
    end
    checks++;
    if (en_after - rise2 !== 6) begin
      failures++;
      $display("FAIL pause_resume dut=%0d exp=6", en_after - rise2);
    end
  endtask

  task automatic test_clear_both();
    int n_clr, n_en, run_late;
    do_reset();
    n_clr = 0; n_en = 0; run_late = 0;
    for (int i = 0; i < 60; i++) begin
      btn_ss = (i < 8) || (i >= 20 && i < 26);
      btn_clr = (i >= 20 && i < 26);
      cyc();
      checks++;
      if (outs !== expv()) begin
        failures++;
        $display("FAIL clr_both i=%0d dut=%b exp=%b", i, outs, expv());
      end
      if (cnt_clr) n_clr++;
      if (cnt_en) n_en++;
      if (i >= 27 && running) run_late++;
    end
    checks++;
    if (n_clr !== 1 || n_en !== 1 || run_late !== 0) begin
      failures++;
      $display("FAIL clr_both_sum clr=%0d en=%0d run=%0d exp 1 1 0",
               n_clr, n_en, run_late);
    end
  endtask

  task automatic test_dir();
    do_reset();
    up_dn = 0;
    for (int i = 0; i < 70; i++) begin
      btn_ss = (i < 8) || (i >= 50 && i < 58);
      btn_clr = (i >= 32 && i < 38);
      if (i == 12) up_dn = 1;
      cyc();
      checks++;
      if (outs !== expv()) begin
        failures++;
        $display("FAIL dir i=%0d dut=%b exp=%b", i, outs, expv());
      end
      if (i == 30 || i == 60) begin
        checks++;
        if (cnt_up !== (i == 60)) begin
          failures++;
          $display("FAIL dir_up i=%0d dut=%b exp=%b", i, cnt_up, i == 60);
        end
      end
    end
  endtask

`ifdef ONESHOT_EN
  task automatic test_oneshot();
    int done_at, n_en;
    do_reset();
    cnt_tc = 1;
    done_at = -1; n_en = 0;
    for (int i = 0; i < 135; i++) begin
      btn_ss = (i < 8) || (i >= 120 && i < 126);
      cyc();
      checks++;
      if (outs !== expv()) begin
        failures++;
        $display("FAIL oneshot i=%0d dut=%b exp=%b", i, outs, expv());
      end
      if (done && done_at < 0) done_at = i;
      if (cnt_en && i < 127) n_en++;
      if (i == 127) begin
        checks++;
        if (outs !== 5'b01110) begin
          failures++;
          $display("FAIL oneshot_restart dut=%b exp=%b", outs, 5'b01110);
        end
      end
    end
    checks++;
    if (done_at !== 18 || n_en !== 1) begin
      failures++;
      $display("FAIL oneshot_done at=%0d en=%0d exp 18 1", done_at, n_en);
    end
    cnt_tc = 0;
  endtask
`endif

  task automatic test_random();
    int hs, hc, rst_at;
    do_reset();
    hs = 0; hc = 0;
    rst_at = $urandom_range(600, 1400);
    for (int i = 0; i < 2000; i++) begin
      if (hs == 0) begin
        btn_ss = $urandom_range(0, 1);
        hs = $urandom_range(1, 12);
      end
      hs--;
      if (hc == 0) begin
        btn_clr = ($urandom_range(0, 7) == 0);
        hc = $urandom_range(1, 10);
      end
      hc--;
      if ($urandom_range(0, 39) == 0) up_dn = ~up_dn;
      cnt_tc = ($urandom_range(0, 3) == 0);
      cyc();
      checks++;
      if (outs !== expv()) begin
        failures++;
        $display("FAIL random i=%0d dut=%b exp=%b", i, outs, expv());
      end
      if (i == rst_at) begin
        rst = 1;
        model_reset();
        #1;
        checks++;
        if (outs !== 5'b00100) begin
          failures++;
          $display("FAIL async_rst dut=%b exp=%b", outs, 5'b00100);
        end
        @(negedge clk);
        rst = 0;
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_glitch();
    test_start();
    test_pause();
    test_clear_both();
    test_dir();
`ifdef ONESHOT_EN
    test_oneshot();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
